// File: rtl/dti_dly_var.sv
// dti_dly_var
//   Runtime-configurable transaction delay line on a valid/ready stream.
//   Output is held back until the latched delay (dly_q) items are buffered,
//   then one item is released per accepted input, so dout lags din by exactly
//   dly_q transactions. A flush pulse drains whatever is buffered.
//
// Parameters
//   MAX_LEN  storage depth / maximum delay (any integer >= 1)
//   W_DIN    data width
//   W_LEN    width of the delay and occupancy fields
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   dly                   requested delay, clamped to [1, MAX_LEN]
//   flush                 single-cycle drain request
//   din_data/valid/ready  input stream
//   dout_data/valid/ready output stream (dout_data = head of buffer)
//   cnt                   registered occupancy
//   primed                registered, high while in RUN
module dti_dly_var #(
  parameter int MAX_LEN = 16,
  parameter int W_DIN   = 16,
  parameter int W_LEN   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_LEN-1:0] dly,
  input  logic             flush,
  input  logic [W_DIN-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W_DIN-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [W_LEN-1:0] cnt,
  output logic             primed
);

  localparam int               W_PTR      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [W_LEN-1:0] L_MAX      = W_LEN'(MAX_LEN);
  localparam logic [W_LEN-1:0] L_ONE      = W_LEN'(1);
  localparam logic [W_PTR-1:0] L_PTR_LAST = W_PTR'(MAX_LEN - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  logic [W_LEN-1:0] r_cnt;
  logic [W_LEN-1:0] r_dly_q;
  logic [W_PTR-1:0] r_wr_ptr;
  logic [W_PTR-1:0] r_rd_ptr;
  logic             r_primed;
  logic [W_DIN-1:0] r_mem [MAX_LEN];

  logic [W_LEN-1:0] w_dly_clamp;
  logic [W_LEN-1:0] w_dly_eff;
  logic             w_din_ready;
  logic             w_dout_valid;
  logic             w_din_acc;
  logic             w_dout_acc;
  logic             w_flush_go;
  logic [W_LEN-1:0] w_cnt_nxt;

  always_comb begin
    w_dly_clamp = dly;
    if (dly == '0)
      w_dly_clamp = L_ONE;
    else if (dly > L_MAX)
      w_dly_clamp = L_MAX;

    // While empty in FILL the delay follows the input live, so the very
    // first accept already uses the current request; otherwise it is frozen.
    w_dly_eff = ((r_state == S_FILL) && (r_cnt == '0)) ? w_dly_clamp : r_dly_q;

    w_din_ready  = 1'b0;
    w_dout_valid = 1'b0;
    case (r_state)
      S_FILL: begin
        w_din_ready  = (r_cnt < w_dly_eff);
        w_dout_valid = 1'b0;
      end
      S_RUN: begin
        w_dout_valid = (r_cnt == w_dly_eff);
        w_din_ready  = (r_cnt < w_dly_eff) || dout_ready;
      end
      S_DRAIN: begin
        w_din_ready  = 1'b0;
        w_dout_valid = (r_cnt != '0);
      end
      default: begin
        w_din_ready  = 1'b0;
        w_dout_valid = 1'b0;
      end
    endcase
    if (rst) begin
      w_din_ready  = 1'b0;
      w_dout_valid = 1'b0;
    end

    w_din_acc  = din_valid && w_din_ready;
    w_dout_acc = w_dout_valid && dout_ready;
    w_cnt_nxt  = r_cnt + W_LEN'(w_din_acc) - W_LEN'(w_dout_acc);

    // An accept in the flush cycle counts as buffered data to drain.
    w_flush_go = flush && (r_state != S_DRAIN) && ((r_cnt != '0) || w_din_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FILL;
      r_cnt    <= '0;
      r_dly_q  <= L_ONE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_primed <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dly_q <= w_dly_eff;

      if (w_din_acc)
        r_wr_ptr <= (r_wr_ptr == L_PTR_LAST) ? '0 : r_wr_ptr + W_PTR'(1);
      if (w_dout_acc)
        r_rd_ptr <= (r_rd_ptr == L_PTR_LAST) ? '0 : r_rd_ptr + W_PTR'(1);

      case (r_state)
        S_FILL: begin
          if (w_flush_go) begin
            r_state  <= S_DRAIN;
            r_primed <= 1'b0;
          end else if (w_cnt_nxt == w_dly_eff) begin
            r_state  <= S_RUN;
            r_primed <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_flush_go) begin
            r_state  <= S_DRAIN;
            r_primed <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_cnt_nxt == '0) begin
            r_state  <= S_FILL;
            r_primed <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_FILL;
          r_primed <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; contents are only observable while dout_valid.
  always_ff @(posedge clk) begin
    if (w_din_acc)
      r_mem[r_wr_ptr] <= din_data;
  end

  assign din_ready  = w_din_ready;
  assign dout_valid = w_dout_valid;
  assign dout_data  = r_mem[r_rd_ptr];
  assign cnt        = r_cnt;
  assign primed     = r_primed;

endmodule

// File: tb/tb_dti_dly_var.sv
module tb_dti_dly_var;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MAX_LEN = 16 (W_LEN = 5)
  logic        a_rst, a_flush, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready, a_primed;
  logic [4:0]  a_dly, a_cnt;
  logic [15:0] a_din_data, a_dout_data;

  // Instance B: MAX_LEN = 6 (W_LEN = 3), non-power-of-two wrap
  logic        b_rst, b_flush, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready, b_primed;
  logic [2:0]  b_dly, b_cnt;
  logic [15:0] b_din_data, b_dout_data;

  dti_dly_var #(.MAX_LEN(16), .W_DIN(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .dly(a_dly), .flush(a_flush),
    .din_data(a_din_data), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .dout_data(a_dout_data), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
    .cnt(a_cnt), .primed(a_primed)
  );

  dti_dly_var #(.MAX_LEN(6), .W_DIN(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .dly(b_dly), .flush(b_flush),
    .din_data(b_din_data), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .dout_data(b_dout_data), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .cnt(b_cnt), .primed(b_primed)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  dly;
    logic        flush;
    logic [15:0] din;
    logic        dv;
    logic        dr;
    logic        e_din_ready;
    logic        e_dout_valid;
    logic        chk_data;
    logic [15:0] e_data;
    logic [4:0]  e_cnt;
    logic        e_primed;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int dly, input int flush, input int din,
                     input int dv, input int dr, input int e_dr, input int e_dv,
                     input int cd, input int e_data, input int e_cnt, input int e_pr);
    vec_t v;
    v.rst = rst[0]; v.dly = dly[4:0]; v.flush = flush[0]; v.din = din[15:0];
    v.dv = dv[0]; v.dr = dr[0]; v.e_din_ready = e_dr[0]; v.e_dout_valid = e_dv[0];
    v.chk_data = cd[0]; v.e_data = e_data[15:0]; v.e_cnt = e_cnt[4:0]; v.e_primed = e_pr[0];
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] q[$];
    int   sent, recv, cyc, sz0;
    bit   primed_m, drain_m, flush_sent, acc_in, acc_out, exp_dv, exp_dr;

    a_rst = 1'b1; a_dly = 5'd5; a_flush = 1'b0; a_din_data = '0; a_din_valid = 1'b0; a_dout_ready = 1'b0;
    b_rst = 1'b1; b_dly = 3'd6; b_flush = 1'b0; b_din_data = '0; b_din_valid = 1'b0; b_dout_ready = 1'b0;

    // ---- table: rst, dly, flush, din, dv, dr | din_ready, dout_valid, chk, data, cnt, primed
    // Frame 1: dly=5, stream 0..19, then flush and drain 15..19
    for (int k = 0; k < 5; k++)  add(0, 5, 0, k, 1, 1,  1, 0, 0, 0, k, 0);
    for (int k = 5; k < 20; k++) add(0, 5, 0, k, 1, 1,  1, 1, 1, k - 5, 5, 1);
    add(0, 5, 1, 0, 0, 1,  1, 1, 1, 15, 5, 1);
    for (int j = 1; j < 5; j++)  add(0, 5, 0, 0, 0, 1,  0, 1, 1, 15 + j, 5 - j, 0);
    // Frame 2: dly=0 clamps to 1; dly=20 during RUN is ignored
    add(0, 0, 0, 100, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 20, 0, 101, 1, 0,  0, 1, 1, 100, 1, 1);
    add(0, 20, 0, 101, 1, 1,  1, 1, 1, 100, 1, 1);
    add(0, 20, 0, 102, 1, 1,  1, 1, 1, 101, 1, 1);
    add(0, 20, 1, 0, 0, 0,  0, 1, 1, 102, 1, 1);
    add(0, 20, 0, 999, 1, 1,  0, 1, 1, 102, 1, 0);
    // Frame 3: dly=20 clamps to 16
    for (int j = 0; j < 16; j++) add(0, 20, 0, 200 + j, 1, 1,  1, 0, 0, 0, j, 0);
    add(0, 3, 0, 0, 0, 0,  0, 1, 1, 200, 16, 1);
    add(0, 3, 0, 0, 0, 0,  0, 1, 1, 200, 16, 1);
    add(0, 3, 0, 216, 1, 1,  1, 1, 1, 200, 16, 1);
    add(0, 3, 0, 0, 0, 1,  1, 1, 1, 201, 16, 1);
    add(0, 3, 0, 0, 0, 1,  1, 0, 0, 0, 15, 1);
    add(0, 3, 0, 217, 1, 1,  1, 0, 0, 0, 15, 1);
    add(0, 3, 0, 0, 0, 0,  0, 1, 1, 202, 16, 1);
    add(0, 3, 1, 0, 0, 1,  1, 1, 1, 202, 16, 1);
    for (int j = 0; j < 12; j++) add(0, 3, 0, 0, 1, 1,  0, 1, 1, 203 + j, 15 - j, 0);
    add(0, 3, 0, 0, 0, 0,  0, 1, 1, 215, 3, 0);
    // Reset while draining with cnt=3
    add(1, 3, 0, 0, 1, 1,  0, 0, 0, 0, 3, 0);
    add(1, 3, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 300, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 3, 0, 301, 1, 0,  1, 0, 0, 0, 1, 0);
    add(0, 3, 0, 302, 1, 0,  1, 0, 0, 0, 2, 0);
    add(0, 3, 0, 303, 1, 0,  0, 1, 1, 300, 3, 1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cnt", 32'(a_cnt), 0);
    chk("reset primed", 32'(a_primed), 0);
    chk("reset din_ready", 32'(a_din_ready), 0);
    chk("reset dout_valid", 32'(a_dout_valid), 0);

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      a_rst = vecs[i].rst; a_dly = vecs[i].dly; a_flush = vecs[i].flush;
      a_din_data = vecs[i].din; a_din_valid = vecs[i].dv; a_dout_ready = vecs[i].dr;
      #1;
      chk($sformatf("v%0d din_ready", i), 32'(a_din_ready), 32'(vecs[i].e_din_ready));
      chk($sformatf("v%0d dout_valid", i), 32'(a_dout_valid), 32'(vecs[i].e_dout_valid));
      chk($sformatf("v%0d cnt", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d primed", i), 32'(a_primed), 32'(vecs[i].e_primed));
      if (vecs[i].chk_data)
        chk($sformatf("v%0d dout_data", i), 32'(a_dout_data), 32'(vecs[i].e_data));
    end

    // ---- MAX_LEN=6, dly=6: random handshakes, scoreboard across pointer wrap
    @(negedge clk);
    b_rst = 1'b0;
    sent = 0; recv = 0; cyc = 0;
    primed_m = 0; drain_m = 0; flush_sent = 0;
    while (recv < 50 && cyc < 2000) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      b_din_valid  = (sent < 50) && ($urandom_range(0, 9) < 7);
      b_din_data   = 16'(1000 + sent);
      b_dout_ready = ($urandom_range(0, 9) < 7);
      b_flush      = (sent == 50) && !flush_sent;
      if (b_flush) flush_sent = 1;
      #1;
      sz0    = q.size();
      exp_dv = drain_m ? (sz0 > 0) : (primed_m && sz0 == 6);
      exp_dr = drain_m ? 1'b0 : ((sz0 < 6) || (primed_m && b_dout_ready));
      chk("wrap dout_valid", 32'(b_dout_valid), 32'(exp_dv));
      chk("wrap din_ready", 32'(b_din_ready), 32'(exp_dr));
      chk("wrap cnt", 32'(b_cnt), 32'(sz0));
      chk("wrap primed", 32'(b_primed), 32'(primed_m));
      acc_in  = b_din_valid && exp_dr;
      acc_out = exp_dv && b_dout_ready;
      if (acc_out) begin
        chk("wrap dout_data", 32'(b_dout_data), 32'(q[0]));
        void'(q.pop_front());
        recv++;
      end
      if (acc_in) begin
        q.push_back(b_din_data);
        sent++;
      end
      if (drain_m) begin
        if (q.size() == 0) drain_m = 0;
      end else if (b_flush && (sz0 > 0 || acc_in)) begin
        drain_m = 1; primed_m = 0;
      end else if (!primed_m && q.size() == 6) begin
        primed_m = 1;
      end
    end
    chk("wrap items received", 32'(recv), 50);
    @(negedge clk);
    b_din_valid = 1'b0; b_flush = 1'b0;
    #1;
    chk("wrap post-drain cnt", 32'(b_cnt), 0);
    chk("wrap post-drain din_ready", 32'(b_din_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
